// File: rtl/adder.sv
// Registered signed adder: C is the full-precision sum of A and B one clock after sampling.
// The result is one bit wider than the operands, so it never overflows.
module adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic signed [WIDTH:0]   C
);

  localparam int unsigned OUT_W = WIDTH + 1;

  logic signed [OUT_W-1:0] c_d;
  logic signed [OUT_W-1:0] c_q;

  // Sign-extend both operands by one bit so every sum is representable.
  always_comb begin
    c_d = {A[WIDTH-1], A} + {B[WIDTH-1], B};
  end

  // Result register; reset takes priority over the add.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign C = c_q;

endmodule

// File: tb/tb_adder.sv
// Bench for adder: an integer-arithmetic reference checked on every falling edge,
// plus directed vectors with hand-computed literal results.
module tb_adder;

  localparam int unsigned WIDTH = 4;

  logic                    clk;
  logic                    reset;
  logic signed [WIDTH-1:0] A;
  logic signed [WIDTH-1:0] B;
  logic signed [WIDTH:0]   C;

  int checks   = 0;
  int failures = 0;

  int model_exp   = 0;
  bit model_valid = 1'b0;

  adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .C     (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what C must hold after each rising edge, from plain integer math.
  always @(posedge clk) begin
    if (reset) begin
      model_exp <= 0;
    end else begin
      model_exp <= int'(A) + int'(B);
    end
    if (reset) model_valid <= 1'b1;
  end

  // Compare process: C is stable and meaningful at every falling edge after the first reset.
  always @(negedge clk) begin
    if (model_valid) check("model", int'(C), model_exp);
  end

  // Drive operands at a falling edge, then check the literal result just after the next rising edge.
  task automatic apply(input int a, input int b, input int exp, input string name);
    @(negedge clk);
    A = WIDTH'(a);
    B = WIDTH'(b);
    @(posedge clk);
    #2;
    check(name, int'(C), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    A     = '0;
    B     = '0;

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("reset_c", int'(C), 0);
    @(negedge clk);
    reset = 1'b0;

    apply(-8, -8, -16, "maxneg_maxneg");
    apply(-8,  7,  -1, "maxneg_maxpos");
    apply(-8,  0,  -8, "maxneg_zero");
    apply( 7, -8,  -1, "maxpos_maxneg");
    apply( 7,  7,  14, "maxpos_maxpos");
    apply( 7,  0,   7, "maxpos_zero");
    apply( 0, -8,  -8, "zero_maxneg");
    apply( 0,  7,   7, "zero_maxpos");
    apply( 0,  0,   0, "zero_zero");
    apply(-3,  5,   2, "mixed_small");

    // Reset with nonzero history and operands still driven.
    apply(7, 7, 14, "hist_pre");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("reset_mid", int'(C), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    check("reset_resume", int'(C), 14);

    // Latency: a mid-cycle operand change must not reach C before the next edge.
    apply(0, 3, 3, "lat_base");
    #1;
    A = WIDTH'(5);
    #1;
    check("lat_hold_a", int'(C), 3);
    @(negedge clk);
    check("lat_hold_b", int'(C), 3);
    @(posedge clk);
    #1;
    check("lat_update", int'(C), 8);

    // Holding operands keeps C constant.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_const", int'(C), 8);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
